// File: rtl/pe_chain_driver.sv
`default_nettype none
// ============================================================================
//  Module      : pe_chain_driver
//  Description : Head-end sequencer for the systolic GF(2^m) PE chain. Issues
//                one command's operand beats per cycle, inserts NOP bubbles on
//                source starvation or missing result credit, and captures
//                chain results into a result FIFO after a fixed latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_chain_driver #(
  parameter int GF_BIT      = 4,
  parameter int OP_CODE_LEN = 4,
  parameter int LEN_W       = 16,
  parameter int CHAIN_LAT   = 8,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [OP_CODE_LEN-1:0] cmd_op,
  input  logic [1:0]             cmd_gauss_op,
  input  logic [LEN_W-1:0]       cmd_len,
  input  logic                   cmd_collect,
  input  logic                   src_valid,
  output logic                   src_ready,
  input  logic [GF_BIT-1:0]      src_data,
  input  logic [GF_BIT-1:0]      src_dataA,
  input  logic [GF_BIT-1:0]      src_dataB,
  output logic                   start_out,
  output logic [OP_CODE_LEN-1:0] op_out,
  output logic [1:0]             gauss_op_out,
  output logic [GF_BIT-1:0]      data_out,
  output logic [GF_BIT-1:0]      dataA_out,
  output logic [GF_BIT-1:0]      dataB_out,
  input  logic [GF_BIT-1:0]      chain_data_in,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [GF_BIT-1:0]      res_data,
  output logic                   done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  // Inflight covers the output stage plus CHAIN_LAT shift stages.
  localparam int IW = $clog2(CHAIN_LAT + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [OP_CODE_LEN-1:0] r_op;
  logic [1:0]             r_gop;
  logic [LEN_W-1:0]       r_len;
  logic                   r_col;
  logic [LEN_W-1:0]       r_issued;

  // r_vld_out travels alongside the beat on the chain outputs; the shift
  // register then follows it down the chain so its last stage lines up with
  // that beat's result on chain_data_in.
  logic                   r_vld_out;
  logic [CHAIN_LAT-1:0]   r_vld_sr;
  logic [IW-1:0]          r_inflight;

  logic [GF_BIT-1:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]          r_count;

  logic [31:0]            w_occ;
  logic                   w_credit_ok;
  logic                   w_issue;
  logic                   w_tap;
  logic                   w_pop;
  logic                   w_inc;

  // Credit uses current-cycle occupancy, so a same-cycle pop is not counted.
  assign w_occ       = 32'(r_count) + 32'(r_inflight);
  assign w_credit_ok = !r_col || (w_occ < 32'(FIFO_DEPTH));
  assign w_issue     = (r_state == S_ISSUE) && src_valid && (r_issued < r_len) && w_credit_ok;
  assign w_tap       = r_vld_sr[CHAIN_LAT-1];
  assign w_pop       = res_ready && (r_count != '0);
  assign w_inc       = w_issue && r_col;

  assign src_ready   = w_issue;
  assign res_valid   = (r_count != '0);
  assign res_data    = res_valid ? r_mem[r_rd_ptr] : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode plus the command/done handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_nxt = (cmd_len == '0) ? S_DRAIN : S_ISSUE;
      end
      S_ISSUE: begin
        if (r_issued >= r_len) w_state_nxt = S_DRAIN;
        else if (w_issue && ((r_issued + LEN_W'(1)) == r_len)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_inflight == '0) begin
          done        = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command latch, beat counter and the registered chain outputs (NOP when idle).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op         <= '0;
      r_gop        <= '0;
      r_len        <= '0;
      r_col        <= 1'b0;
      r_issued     <= '0;
      start_out    <= 1'b0;
      op_out       <= '0;
      gauss_op_out <= '0;
      data_out     <= '0;
      dataA_out    <= '0;
      dataB_out    <= '0;
      r_vld_out    <= 1'b0;
    end else begin
      if (r_state == S_IDLE && cmd_valid) begin
        r_op     <= cmd_op;
        r_gop    <= cmd_gauss_op;
        r_len    <= cmd_len;
        r_col    <= cmd_collect;
        r_issued <= '0;
      end else if (w_issue) begin
        r_issued <= r_issued + LEN_W'(1);
      end
      if (w_issue) begin
        start_out    <= (r_issued == '0);
        op_out       <= r_op;
        gauss_op_out <= r_gop;
        data_out     <= src_data;
        dataA_out    <= src_dataA;
        dataB_out    <= src_dataB;
      end else begin
        start_out    <= 1'b0;
        op_out       <= '0;
        gauss_op_out <= '0;
        data_out     <= '0;
        dataA_out    <= '0;
        dataB_out    <= '0;
      end
      r_vld_out <= w_inc;
    end
  end

  // Result-valid shift register and the count of uncaptured collected beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_sr   <= '0;
      r_inflight <= '0;
    end else begin
      r_vld_sr[0] <= r_vld_out;
      for (int i = 1; i < CHAIN_LAT; i++) r_vld_sr[i] <= r_vld_sr[i-1];
      if (w_inc && !w_tap)      r_inflight <= r_inflight + IW'(1);
      else if (!w_inc && w_tap) r_inflight <= r_inflight - IW'(1);
    end
  end

  // FIFO storage; contents need no reset because res_data is gated by occupancy.
  always_ff @(posedge clk) begin
    if (w_tap) r_mem[r_wr_ptr] <= chain_data_in;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_tap) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_tap, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire
